npc_pc_unit: RTL and testbench
==============================

Name: npc_pc_unit

Overview:
- Parametrised next-generation PC unit for the MIPS datapath.
- Combines the PC register with the next-PC selector.
- Extends next-PC selection to six branch conditions, exception redirect, stall hold with a latched pending redirect, and a JR alignment check.
- Sits between instruction memory (addressed by pc) and the controller/register file; supplies pc_link to the GPR write-back mux.

Parameters:
ADDR_W, 32, byte-address width; legal range 28..32; pc is held as a word address [ADDR_W-1:2]
RESET_PC, 32'h0000_3000, byte address loaded on reset; low ADDR_W bits used; bits [1:0] ignored
EXC_PC, 32'h0000_4180, byte address of the exception vector; low ADDR_W bits used
RAS_DEPTH, 4, return-address-stack entries (only with RAS_EN); power of two, 2..16

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
stall  in  1  1 = hold pc this cycle
npc_op  in  3  0 SEQ, 1 BRANCH, 2 J, 3 JAL, 4 JR; 5..7 treated as SEQ
br_cond  in  3  0 BEQ, 1 BNE, 2 BLEZ, 3 BGTZ, 4 BLTZ, 5 BGEZ; 6..7 never taken
instr  in  26  instruction bits [25:0]: imm16 = [15:0], index = [25:0]
rs_data  in  32  GPR[rs]
rt_data  in  32  GPR[rt]
exc_req  in  1  request redirect to EXC_PC
pc  out  ADDR_W-2  current word address [ADDR_W-1:2]
pc_link  out  ADDR_W  byte address (pc+1)<<2
taken  out  1  combinational: current instruction redirects (branch taken, J, JAL, JR)
redirect_pending  out  1  an exception redirect is latched and waiting for stall to drop
align_err  out  1  registered: last accepted JR had rs_data[1:0] != 0
ras_mispredict  out  1  see Optional Feature; 0 when feature is absent

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- On a clk edge with reset_n == 0: pc <= RESET_PC[ADDR_W-1:2]; redirect_pending <= 0; align_err <= 0; RAS cleared.
- Reset takes priority over every other input.
- Word-address arithmetic is done modulo 2^(ADDR_W-2), so wrap-around at the top of the address space is silent.
- Next-PC targets:
  - SEQ: pc+1.
  - BRANCH taken: pc+1+sext(imm16). Not taken: pc+1.
  - J and JAL: {pc[ADDR_W-1:28], index}. For ADDR_W = 28 the target is index only.
  - JR: rs_data[ADDR_W-1:2].
- Branch conditions treat rs_data and rt_data as signed 32-bit values:
  - BEQ: rs == rt. BNE: rs != rt.
  - BLEZ: rs <= 0. BGTZ: rs > 0.
  - BLTZ: rs < 0. BGEZ: rs >= 0.
  - BLEZ, BGTZ, BLTZ and BGEZ ignore rt_data.
- Update priority at each edge when reset_n == 1:
  1. stall == 1: pc holds. If exc_req == 1, set redirect_pending <= 1. align_err holds.
  2. stall == 0 and (exc_req or redirect_pending): pc <= EXC_PC[ADDR_W-1:2]; redirect_pending <= 0; npc_op is discarded.
  3. Otherwise: pc <= computed next PC.
- align_err is written on every accepted cycle (stall == 0 and no exception redirect):
  - 1 if npc_op == JR and rs_data[1:0] != 0; otherwise 0.
  - A misaligned JR still jumps to the truncated target. Trap handling belongs to the CP0 block.
- exc_req arriving in the same cycle that stall drops is applied immediately; no extra cycle.
- A pending redirect survives any number of stall cycles.
- Reset while redirect_pending == 1 clears it.
- pc_link and taken are combinational from the current pc and inputs. Both are valid regardless of stall.

Optional Feature:
- Macro: NPC_RAS_EN.
- With the macro defined:
  - A circular return-address stack of RAS_DEPTH entries, each ADDR_W-2 bits, with a fill count 0..RAS_DEPTH.
  - An accepted JAL pushes pc+1.
  - Push when full overwrites the oldest entry; the count saturates at RAS_DEPTH.
  - An accepted JR pops the top entry.
  - ras_mispredict <= 1 for exactly one cycle after an accepted JR if the stack was empty or the popped entry != rs_data[ADDR_W-1:2]; otherwise 0.
  - Exception redirects and stalled cycles neither push nor pop.
- Without the macro: no stack storage; ras_mispredict is tied to 0.

Test Plan:
1. Reset with reset_n = 0 for 2 cycles, then SEQ for 3 cycles -> pc = 0x3000>>2, then 0xC01, 0xC02, 0xC03; pc_link = 0x3004 while pc = 0xC00.
2. Branches: pc = 0xC00, BEQ, rs = rt = 5, imm16 = 16'hFFFE -> taken = 1, next pc 0xBFF. Same setup with BGEZ and rs = 32'h8000_0000 -> taken = 0, next pc 0xC01.
3. Jumps: J, index = 26'h0000100, pc = 0xC00 -> next pc 0x100. JR with rs_data = 0x3010 -> next pc 0xC04, align_err = 0. JR with rs_data = 0x3012 -> next pc 0xC04, align_err = 1.
4. Stalled exception: stall = 1 for 3 cycles with exc_req pulsed on cycle 1 -> pc held, redirect_pending = 1. On the cycle after stall drops: pc = 0x4180>>2, redirect_pending = 0.
5. Reset mid-operation: reset_n = 0 while redirect_pending = 1 -> pc = 0xC00, redirect_pending = 0, no later exception jump.
6. NPC_RAS_EN, RAS_DEPTH = 4: 5 JALs, then 4 JRs to the matching returns -> ras_mispredict 0,0,0,0. A 5th JR (stack empty) -> ras_mispredict = 1 for exactly one cycle.

Source files
------------

// File: rtl/npc_pc_unit.sv
// rtl/npc_pc_unit.sv - PC register and next-PC selector with branch, jump, exception and stall handling
// Optional return-address stack enabled by defining NPC_RAS_EN.
module npc_pc_unit #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_PC    = 32'h0000_4180,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic [2:0]        npc_op,
  input  logic [2:0]        br_cond,
  input  logic [25:0]       instr,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  input  logic              exc_req,
  output logic [ADDR_W-3:0] pc,
  output logic [ADDR_W-1:0] pc_link,
  output logic              taken,
  output logic              redirect_pending,
  output logic              align_err,
  output logic              ras_mispredict
);

  localparam int unsigned PW = ADDR_W - 2;
  localparam logic [PW-1:0] RESET_W = RESET_PC[ADDR_W-1:2];
  localparam logic [PW-1:0] EXC_W   = EXC_PC[ADDR_W-1:2];

  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_J      = 3'd2;
  localparam logic [2:0] OP_JAL    = 3'd3;
  localparam logic [2:0] OP_JR     = 3'd4;

  if (ADDR_W < 28 || ADDR_W > 32) begin : g_bad_addr_w
    $error("npc_pc_unit: ADDR_W must be 28..32");
  end
  if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
    $error("npc_pc_unit: RAS_DEPTH must be a power of two in 2..16");
  end

  logic [PW-1:0] pc_q, pc_d;
  logic          pend_q, pend_d;
  logic          align_q, align_d;

  logic [PW-1:0] pc_inc, br_tgt, j_tgt, npc;
  logic signed [31:0] rs_s, rt_s;
  logic          br_ok, exc_go, accept;

  assign rs_s   = rs_data;
  assign rt_s   = rt_data;
  assign pc_inc = pc_q + PW'(1);
  assign br_tgt = pc_inc + {{(PW-16){instr[15]}}, instr[15:0]};
  assign exc_go = exc_req | pend_q;
  assign accept = ~stall & ~exc_go;

  always_comb begin
    br_ok = 1'b0;
    case (br_cond)
      3'd0:    br_ok = (rs_s == rt_s);
      3'd1:    br_ok = (rs_s != rt_s);
      3'd2:    br_ok = (rs_s <= 0);
      3'd3:    br_ok = (rs_s > 0);
      3'd4:    br_ok = (rs_s < 0);
      3'd5:    br_ok = (rs_s >= 0);
      default: br_ok = 1'b0;
    endcase
  end

  // Index replaces the low 26 word-address bits; with ADDR_W = 28 that is the whole pc.
  always_comb begin
    j_tgt        = pc_q;
    j_tgt[25:0]  = instr;
  end

  always_comb begin
    npc   = pc_inc;
    taken = 1'b0;
    case (npc_op)
      OP_BRANCH: begin
        npc   = br_ok ? br_tgt : pc_inc;
        taken = br_ok;
      end
      OP_J, OP_JAL: begin
        npc   = j_tgt;
        taken = 1'b1;
      end
      OP_JR: begin
        npc   = rs_data[ADDR_W-1:2];
        taken = 1'b1;
      end
      default: begin
        npc   = pc_inc;
        taken = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    pend_d  = pend_q;
    align_d = align_q;
    if (stall) begin
      pend_d = pend_q | exc_req;
    end else if (exc_go) begin
      pc_d   = EXC_W;
      pend_d = 1'b0;
    end else begin
      pc_d    = npc;
      align_d = (npc_op == OP_JR) && (rs_data[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RESET_W;
      pend_q  <= 1'b0;
      align_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      align_q <= align_d;
    end
  end

  assign pc               = pc_q;
  assign pc_link          = {pc_inc, 2'b00};
  assign redirect_pending = pend_q;
  assign align_err        = align_q;

`ifdef NPC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [PW-1:0]    ras_q [RAS_DEPTH];
  logic [PW-1:0]    ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d, top_idx;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             mis_q, mis_d;

  assign top_idx = wp_q - PTR_W'(1);

  // Write pointer wraps, so a push into a full stack lands on the oldest entry.
  always_comb begin
    ras_d = ras_q;
    wp_d  = wp_q;
    cnt_d = cnt_q;
    mis_d = 1'b0;
    if (accept && npc_op == OP_JAL) begin
      ras_d[wp_q] = pc_inc;
      wp_d        = wp_q + PTR_W'(1);
      if (cnt_q != (PTR_W+1)'(RAS_DEPTH)) cnt_d = cnt_q + (PTR_W+1)'(1);
    end else if (accept && npc_op == OP_JR) begin
      if (cnt_q == '0) begin
        mis_d = 1'b1;
      end else begin
        mis_d = (ras_q[top_idx] != rs_data[ADDR_W-1:2]);
        wp_d  = top_idx;
        cnt_d = cnt_q - (PTR_W+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
      mis_q <= 1'b0;
    end else begin
      ras_q <= ras_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      mis_q <= mis_d;
    end
  end

  assign ras_mispredict = mis_q;
`else
  assign ras_mispredict = 1'b0;
`endif

endmodule

// File: tb/tb_npc_pc_unit.sv
// tb/tb_npc_pc_unit.sv - randomized and directed bench for npc_pc_unit against a behavioural model
// Exercises the return-address stack when NPC_RAS_EN is defined.
module tb_npc_pc_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic [2:0]  npc_op = 3'd0;
  logic [2:0]  br_cond = 3'd0;
  logic [25:0] instr = 26'd0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        exc_req = 1'b0;
  logic [29:0] pc;
  logic [31:0] pc_link;
  logic        taken, redirect_pending, align_err, ras_mispredict;

  int errors = 0;
  int checks = 0;

  logic [29:0] m_pc = '0;
  bit          m_pend = 0, m_align = 0, m_mis = 0, m_valid = 0;
  logic [29:0] m_ras[$];
  logic        last_taken;

  npc_pc_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .npc_op(npc_op), .br_cond(br_cond),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data), .exc_req(exc_req),
    .pc(pc), .pc_link(pc_link), .taken(taken), .redirect_pending(redirect_pending),
    .align_err(align_err), .ras_mispredict(ras_mispredict)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit exp_taken(input logic [2:0] op, input logic [2:0] cond,
                                   input logic [31:0] rs, input logic [31:0] rt);
    int a, b;
    a = rs;
    b = rt;
    if (op == 3'd2 || op == 3'd3 || op == 3'd4) return 1'b1;
    if (op != 3'd1) return 1'b0;
    case (cond)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd2: return a <= 0;
      3'd3: return a > 0;
      3'd4: return a < 0;
      3'd5: return a >= 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_update();
    int s;
    logic [29:0] top;
    if (!reset_n) begin
      m_pc = 30'h3000 >> 2;
      m_pend = 0; m_align = 0; m_mis = 0; m_valid = 1;
      m_ras.delete();
    end else if (stall) begin
      if (exc_req) m_pend = 1;
      m_mis = 0;
    end else if (exc_req || m_pend) begin
      m_pc = 30'h4180 >> 2;
      m_pend = 0; m_mis = 0;
    end else begin
      m_mis = 0;
      m_align = (npc_op == 3'd4) && (rs_data[1:0] != 2'b00);
      s = $signed(instr[15:0]);
      case (npc_op)
        3'd1: m_pc = exp_taken(npc_op, br_cond, rs_data, rt_data) ? 30'(m_pc + 1 + s) : 30'(m_pc + 1);
        3'd2: m_pc = {m_pc[29:26], instr};
        3'd3: begin
`ifdef NPC_RAS_EN
          if (m_ras.size() == 4) void'(m_ras.pop_front());
          m_ras.push_back(30'(m_pc + 1));
`endif
          m_pc = {m_pc[29:26], instr};
        end
        3'd4: begin
`ifdef NPC_RAS_EN
          if (m_ras.size() == 0) m_mis = 1;
          else begin
            top = m_ras.pop_back();
            m_mis = (top != rs_data[31:2]);
          end
`endif
          m_pc = rs_data[31:2];
        end
        default: m_pc = 30'(m_pc + 1);
      endcase
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc", {2'b00, pc}, {2'b00, m_pc});
      chk("pc_link", pc_link, {30'(m_pc + 1), 2'b00});
      chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, m_pend});
      chk("align_err", {31'd0, align_err}, {31'd0, m_align});
      chk("ras_mispredict", {31'd0, ras_mispredict}, {31'd0, m_mis});
      chk("taken", {31'd0, taken}, {31'd0, exp_taken(npc_op, br_cond, rs_data, rt_data)});
    end
  end

  task automatic run(input bit rn, input bit st, input bit ex, input logic [2:0] op,
                     input logic [2:0] cond, input logic [25:0] ins,
                     input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    #2;
    reset_n = rn; stall = st; exc_req = ex; npc_op = op; br_cond = cond;
    instr = ins; rs_data = rs; rt_data = rt;
    #1 last_taken = taken;
    @(posedge clk);
    #1 model_update();
  endtask

  task automatic rst();
    run(0, 0, 0, 3'd0, 3'd0, 26'd0, 32'd0, 32'd0);
  endtask

  task automatic seq();
    run(1, 0, 0, 3'd0, 3'd0, 26'd0, 32'd0, 32'd0);
  endtask

  task automatic lit_pc(input string name, input logic [29:0] exp);
    chk(name, {2'b00, pc}, {2'b00, exp});
    chk({name, "_model"}, {2'b00, m_pc}, {2'b00, exp});
  endtask

  initial begin
    logic [31:0] rs, rt;
    logic [2:0]  op;
    // reset and sequential flow
    rst(); rst();
    lit_pc("rst_pc", 30'hC00);
    chk("rst_link", pc_link, 32'h3004);
    seq(); lit_pc("seq1", 30'hC01);
    seq(); lit_pc("seq2", 30'hC02);
    seq(); lit_pc("seq3", 30'hC03);
    // branches
    rst();
    run(1, 0, 0, 3'd1, 3'd0, 26'h000FFFE, 32'd5, 32'd5);
    chk("beq_taken", {31'd0, last_taken}, 32'd1);
    lit_pc("beq_pc", 30'hBFF);
    rst();
    run(1, 0, 0, 3'd1, 3'd5, 26'h000FFFE, 32'h8000_0000, 32'd0);
    chk("bgez_taken", {31'd0, last_taken}, 32'd0);
    lit_pc("bgez_pc", 30'hC01);
    // jumps
    rst();
    run(1, 0, 0, 3'd2, 3'd0, 26'h0000100, 32'd0, 32'd0);
    lit_pc("j_pc", 30'h100);
    rst();
    run(1, 0, 0, 3'd4, 3'd0, 26'd0, 32'h3010, 32'd0);
    lit_pc("jr_pc", 30'hC04);
    chk("jr_align0", {31'd0, align_err}, 32'd0);
    run(1, 0, 0, 3'd4, 3'd0, 26'd0, 32'h3012, 32'd0);
    lit_pc("jr_mis_pc", 30'hC04);
    chk("jr_align1", {31'd0, align_err}, 32'd1);
    // stalled exception
    run(1, 1, 1, 3'd0, 3'd0, 26'd0, 32'd0, 32'd0);
    lit_pc("stall1_pc", 30'hC04);
    chk("stall1_pend", {31'd0, redirect_pending}, 32'd1);
    run(1, 1, 0, 3'd2, 3'd0, 26'd5, 32'd0, 32'd0);
    run(1, 1, 0, 3'd0, 3'd0, 26'd0, 32'd0, 32'd0);
    lit_pc("stall3_pc", 30'hC04);
    chk("stall3_pend", {31'd0, redirect_pending}, 32'd1);
    run(1, 0, 0, 3'd2, 3'd0, 26'd7, 32'd0, 32'd0);
    lit_pc("exc_pc", 30'h1060);
    chk("exc_pend", {31'd0, redirect_pending}, 32'd0);
    chk("exc_align_hold", {31'd0, align_err}, 32'd1);
    seq();
    chk("seq_align_clr", {31'd0, align_err}, 32'd0);
    run(1, 0, 1, 3'd0, 3'd0, 26'd0, 32'd0, 32'd0);
    lit_pc("exc_now_pc", 30'h1060);
    // reset clears pending redirect
    run(1, 1, 1, 3'd0, 3'd0, 26'd0, 32'd0, 32'd0);
    chk("pre_rst_pend", {31'd0, redirect_pending}, 32'd1);
    rst();
    lit_pc("mid_rst_pc", 30'hC00);
    chk("mid_rst_pend", {31'd0, redirect_pending}, 32'd0);
    seq();
    lit_pc("post_rst_pc", 30'hC01);
`ifdef NPC_RAS_EN
    rst();
    for (int i = 1; i <= 5; i++) run(1, 0, 0, 3'd3, 3'd0, 26'(i * 32'h100), 32'd0, 32'd0);
    lit_pc("jal5_pc", 30'h500);
    for (int i = 4; i >= 1; i--) begin
      run(1, 0, 0, 3'd4, 3'd0, 26'd0, {30'(i * 32'h100 + 1), 2'b00}, 32'd0);
      chk($sformatf("ras_hit%0d", i), {31'd0, ras_mispredict}, 32'd0);
    end
    run(1, 0, 0, 3'd4, 3'd0, 26'd0, 32'h0000_3004, 32'd0);
    chk("ras_empty", {31'd0, ras_mispredict}, 32'd1);
    seq();
    chk("ras_one_cycle", {31'd0, ras_mispredict}, 32'd0);
`endif
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: rs = 32'd0;
        1: rs = $urandom;
        2: rs = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: rs = $urandom_range(0, 4);
      endcase
      rt = ($urandom_range(0, 2) == 0) ? rs : $urandom;
      op = 3'($urandom_range(0, 7));
`ifdef NPC_RAS_EN
      if (op == 3'd4 && m_ras.size() > 0 && $urandom_range(0, 1) == 1)
        rs = {m_ras[$], 2'($urandom_range(0, 3))};
`endif
      run($urandom_range(0, 49) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0,
          op, 3'($urandom_range(0, 7)), 26'($urandom), rs, rt);
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
